// File: rtl/serial_link_pkg.sv
// ---------------------------------------------------------------------------
// serial_link_pkg
//
// Purpose:
//   Shared definitions for the team's serial link. Both the transmitter
//   (serial_frame_tx) and the matching deserializer import this package, so
//   the frame states and line levels stay in agreement on both ends.
//
// Contents:
//   txState_e  - frame state machine encoding (IDLE, START, DATA, PARITY, STOP)
//   LINE_IDLE  - level held on the line between frames
//   START_LVL  - level of the start bit
//   STOP_LVL   - level of the stop bit
// ---------------------------------------------------------------------------
package serial_link_pkg;

    // Frame sequencing: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_e;

    // Line levels. The line idles high so a falling edge marks a start bit.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
//
// Purpose:
//   Bit-period timer for the serial transmitter. While enabled it counts
//   0..BAUD_DIV-1 and raises tick_o during the final cycle of every bit
//   period, then wraps to 0. While disabled the counter is held at 0, so the
//   first bit after enabling always lasts a full BAUD_DIV cycles.
//
// Parameters:
//   BAUD_DIV - clock cycles per serial bit (>= 1)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   en_i    in   count enable; counter clears when low
//   tick_o  out  high in the last cycle of each bit period
// ---------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    // With BAUD_DIV=1 $clog2 would give 0, so the counter is kept one bit
    // wide; it then sits at 0 and every enabled cycle is a tick.
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] baudCnt_q;
    logic [CNT_W-1:0] baudCnt_d;

    // The counter wraps on the last count so it never leaves 0..BAUD_DIV-1,
    // and it is forced to zero whenever the transmitter is idle.
    always_comb begin
        baudCnt_d = baudCnt_q;
        if (!en_i) begin
            baudCnt_d = '0;
        end else if (baudCnt_q == LAST_CNT) begin
            baudCnt_d = '0;
        end else begin
            baudCnt_d = baudCnt_q + 1'b1;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baudCnt_q <= '0;
        end else begin
            baudCnt_q <= baudCnt_d;
        end
    end

    assign tick_o = en_i && (baudCnt_q == LAST_CNT);

endmodule

// File: rtl/serial_frame_tx.sv
// ---------------------------------------------------------------------------
// serial_frame_tx
//
// Purpose:
//   Parallel-in, serial-out frame transmitter. A DATA_W-bit word taken over
//   a valid/ready handshake is sent as: start bit (0), data LSB first,
//   optional parity bit, stop bit (1). Each bit lasts BAUD_DIV clock cycles.
//   The serial output is registered, so the start bit appears in the cycle
//   right after the accepting clock edge.
//
// Parameters:
//   DATA_W   - payload width (>= 2)
//   BAUD_DIV - clock cycles per bit (>= 1)
//   PAR_EN   - 1 inserts a parity bit after the data, 0 omits it
//   PAR_ODD  - 0 even parity (XOR of data), 1 odd parity (inverse)
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   tx_data_i   in   word to send, sampled only on handshake
//   tx_valid_i  in   tx_data_i is valid
//   tx_ready_o  out  a word can be accepted this cycle (IDLE only)
//   ser_out_o   out  serial line, idles high
//   busy_o      out  a frame is in progress (START..STOP)
//   done_o      out  one-cycle pulse in the first IDLE cycle after STOP
// ---------------------------------------------------------------------------
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 4,
    parameter int PAR_EN   = 1,
    parameter int PAR_ODD  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              ser_out_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic PAR_INV = (PAR_ODD != 0);

    txState_e          state_q;
    txState_e          state_d;
    logic [DATA_W-1:0] shiftReg_q;
    logic [DATA_W-1:0] shiftReg_d;
    logic [BIT_W-1:0]  bitCnt_q;
    logic [BIT_W-1:0]  bitCnt_d;
    logic              parity_q;
    logic              parity_d;
    logic              serOut_q;
    logic              serOut_d;
    logic              done_q;
    logic              done_d;

    logic              baudTick;
    logic              accept;

    // Bit timer runs only while a frame is on the line, so it always starts
    // a new frame from count zero.
    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .tick_o (baudTick)
    );

    assign accept = tx_valid_i && (state_q == IDLE);

    // Next-state logic. The word and its parity are captured at accept time,
    // so later changes on tx_data_i cannot disturb the frame in flight. The
    // shift register moves right on every data bit boundary, which leaves the
    // next data bit in bit 0.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitCnt_d   = bitCnt_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    shiftReg_d = tx_data_i;
                    parity_d   = (^tx_data_i) ^ PAR_INV;
                    bitCnt_d   = '0;
                end
            end

            START: begin
                if (baudTick) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                end
            end

            DATA: begin
                if (baudTick) begin
                    shiftReg_d = shiftReg_q >> 1;
                    if (bitCnt_q == LAST_BIT) begin
                        bitCnt_d = '0;
                        state_d  = (PAR_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (baudTick) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                if (baudTick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is derived from the state being entered, so the registered
    // output changes on the same edge as the state and no bit is delayed by
    // an extra cycle.
    always_comb begin
        serOut_d = LINE_IDLE;
        case (state_d)
            IDLE:    serOut_d = LINE_IDLE;
            START:   serOut_d = START_LVL;
            DATA:    serOut_d = shiftReg_d[0];
            PARITY:  serOut_d = parity_d;
            STOP:    serOut_d = STOP_LVL;
            default: serOut_d = LINE_IDLE;
        endcase
    end

    // State and datapath registers. Reset drives the line high at once and
    // drops any partial frame without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            parity_q   <= 1'b0;
            serOut_q   <= LINE_IDLE;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= bitCnt_d;
            parity_q   <= parity_d;
            serOut_q   <= serOut_d;
            done_q     <= done_d;
        end
    end

    assign ser_out_o  = serOut_q;
    assign tx_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Purpose:
//   Directed bench for serial_frame_tx. Instance "a" uses the default
//   configuration (DATA_W=8, BAUD_DIV=4, even parity); instance "b" uses
//   BAUD_DIV=1 with no parity. Expected line levels come from a small frame
//   model indexed by the cycle number after the accept edge.
// ---------------------------------------------------------------------------
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;

    logic [7:0] aTxData;
    logic       aTxValid;
    logic       aTxReady;
    logic       aSerOut;
    logic       aBusy;
    logic       aDone;

    logic [7:0] bTxData;
    logic       bTxValid;
    logic       bTxReady;
    logic       bSerOut;
    logic       bBusy;
    logic       bDone;

    int checkCount;
    int errorCount;

    serial_frame_tx #(
        .DATA_W   (8),
        .BAUD_DIV (4),
        .PAR_EN   (1),
        .PAR_ODD  (0)
    ) dutA (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data_i  (aTxData),
        .tx_valid_i (aTxValid),
        .tx_ready_o (aTxReady),
        .ser_out_o  (aSerOut),
        .busy_o     (aBusy),
        .done_o     (aDone)
    );

    serial_frame_tx #(
        .DATA_W   (8),
        .BAUD_DIV (1),
        .PAR_EN   (0),
        .PAR_ODD  (1)
    ) dutB (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data_i  (bTxData),
        .tx_valid_i (bTxValid),
        .tx_ready_o (bTxReady),
        .ser_out_o  (bSerOut),
        .busy_o     (bBusy),
        .done_o     (bDone)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected line level in cycle k (1 = first cycle after the accept edge).
    function automatic logic expBit(input logic [7:0] d, input int k,
                                    input int baud, input int parEn,
                                    input logic parOdd);
        int nb;
        int idx;
        nb = 10 + parEn;
        if (k < 1 || k > nb * baud) return 1'b1;
        idx = (k - 1) / baud;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (parEn != 0 && idx == 9) return (^d) ^ parOdd;
        return 1'b1;
    endfunction

    function automatic logic expBusy(input int k, input int len);
        return (k >= 1) && (k <= len);
    endfunction

    function automatic logic expDone(input int k, input int len);
        return (k == len + 1);
    endfunction

    // Reset held for three cycles: both instances must sit idle.
    task automatic test_reset();
        rst_n    = 1'b0;
        aTxValid = 1'b0;
        aTxData  = 8'h00;
        bTxValid = 1'b0;
        bTxData  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkCount++;
            if (aSerOut !== 1'b1) begin
                errorCount++;
                $display("[TB] FAIL reset ser_out got %b exp 1", aSerOut);
            end
            checkCount++;
            if (aTxReady !== 1'b1) begin
                errorCount++;
                $display("[TB] FAIL reset tx_ready got %b exp 1", aTxReady);
            end
            checkCount++;
            if (aBusy !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL reset busy got %b exp 0", aBusy);
            end
            checkCount++;
            if (aDone !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL reset done got %b exp 0", aDone);
            end
            checkCount++;
            if (bSerOut !== 1'b1 || bTxReady !== 1'b1) begin
                errorCount++;
                $display("[TB] FAIL reset_b ser/ready got %b%b exp 11", bSerOut, bTxReady);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One 0xA5 frame, checked cycle by cycle through the done pulse.
    task automatic test_single_frame();
        logic eSer;
        @(posedge clk);
        #1;
        aTxData  = 8'hA5;
        aTxValid = 1'b1;
        @(negedge clk);
        checkCount++;
        if (aTxReady !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL single tx_ready got %b exp 1", aTxReady);
        end
        @(posedge clk);
        #1 aTxValid = 1'b0;
        for (int k = 1; k <= 47; k++) begin
            @(negedge clk);
            eSer = expBit(8'hA5, k, 4, 1, 1'b0);
            checkCount++;
            if (aSerOut !== eSer) begin
                errorCount++;
                $display("[TB] FAIL single ser_out k=%0d got %b exp %b", k, aSerOut, eSer);
            end
            checkCount++;
            if (aBusy !== expBusy(k, 44)) begin
                errorCount++;
                $display("[TB] FAIL single busy k=%0d got %b exp %b", k, aBusy, expBusy(k, 44));
            end
            checkCount++;
            if (aDone !== expDone(k, 44)) begin
                errorCount++;
                $display("[TB] FAIL single done k=%0d got %b exp %b", k, aDone, expDone(k, 44));
            end
        end
    endtask

    // tx_valid held high across 0x00 then 0xFF: second start bit 45 cycles
    // after the first, one idle cycle between frames.
    task automatic test_back_to_back();
        logic eSer;
        logic eBusy;
        logic eDone;
        @(posedge clk);
        #1;
        aTxData  = 8'h00;
        aTxValid = 1'b1;
        @(posedge clk);
        #1 aTxData = 8'hFF;
        for (int k = 1; k <= 92; k++) begin
            @(negedge clk);
            eSer  = expBit(8'h00, k, 4, 1, 1'b0) & expBit(8'hFF, k - 45, 4, 1, 1'b0);
            eBusy = expBusy(k, 44) | expBusy(k - 45, 44);
            eDone = expDone(k, 44) | expDone(k - 45, 44);
            checkCount++;
            if (aSerOut !== eSer) begin
                errorCount++;
                $display("[TB] FAIL b2b ser_out k=%0d got %b exp %b", k, aSerOut, eSer);
            end
            checkCount++;
            if (aBusy !== eBusy || aDone !== eDone) begin
                errorCount++;
                $display("[TB] FAIL b2b busy/done k=%0d got %b%b exp %b%b", k, aBusy, aDone, eBusy, eDone);
            end
            if (k == 45) begin
                checkCount++;
                if (aTxReady !== 1'b1) begin
                    errorCount++;
                    $display("[TB] FAIL b2b gap tx_ready got %b exp 1", aTxReady);
                end
                @(posedge clk);
                #1 aTxValid = 1'b0;
            end
        end
    endtask

    // Valid and changing data while busy must be ignored.
    task automatic test_busy_ignore();
        logic eSer;
        @(posedge clk);
        #1;
        aTxData  = 8'h5A;
        aTxValid = 1'b1;
        @(posedge clk);
        #1 aTxValid = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            eSer = expBit(8'h5A, k, 4, 1, 1'b0);
            checkCount++;
            if (aSerOut !== eSer) begin
                errorCount++;
                $display("[TB] FAIL ignore ser_out k=%0d got %b exp %b", k, aSerOut, eSer);
            end
            checkCount++;
            if (aTxReady !== !expBusy(k, 44)) begin
                errorCount++;
                $display("[TB] FAIL ignore tx_ready k=%0d got %b exp %b", k, aTxReady, !expBusy(k, 44));
            end
            checkCount++;
            if (aBusy !== expBusy(k, 44) || aDone !== expDone(k, 44)) begin
                errorCount++;
                $display("[TB] FAIL ignore busy/done k=%0d got %b%b exp %b%b", k, aBusy, aDone, expBusy(k, 44), expDone(k, 44));
            end
            if (k == 10) begin
                aTxValid = 1'b1;
                aTxData  = 8'h3C;
            end
            if (k == 25) aTxData = 8'hC3;
            if (k == 40) aTxValid = 1'b0;
        end
    endtask

    // Reset asserted during the 3rd data bit, then a clean 0x81 frame.
    task automatic test_mid_reset();
        logic [7:0] words [2];
        logic       eSer;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        for (int w = 0; w < 2; w++) begin
            @(posedge clk);
            #1;
            aTxData  = words[w];
            aTxValid = 1'b1;
            @(posedge clk);
            #1 aTxValid = 1'b0;
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                eSer = expBit(words[w], k, 4, 1, 1'b0);
                checkCount++;
                if (aSerOut !== eSer) begin
                    errorCount++;
                    $display("[TB] FAIL midrst pre ser_out k=%0d got %b exp %b", k, aSerOut, eSer);
                end
            end
            @(negedge clk);
            #1 rst_n = 1'b0;
            #1;
            checkCount++;
            if (aSerOut !== 1'b1 || aBusy !== 1'b0 || aTxReady !== 1'b1) begin
                errorCount++;
                $display("[TB] FAIL midrst async ser/busy/ready got %b%b%b exp 101", aSerOut, aBusy, aTxReady);
            end
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                checkCount++;
                if (aDone !== 1'b0 || aSerOut !== 1'b1 || aBusy !== 1'b0) begin
                    errorCount++;
                    $display("[TB] FAIL midrst post done/ser/busy got %b%b%b exp 010", aDone, aSerOut, aBusy);
                end
            end
        end
        @(posedge clk);
        #1;
        aTxData  = 8'h81;
        aTxValid = 1'b1;
        @(posedge clk);
        #1 aTxValid = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            eSer = expBit(8'h81, k, 4, 1, 1'b0);
            checkCount++;
            if (aSerOut !== eSer) begin
                errorCount++;
                $display("[TB] FAIL midrst 81 ser_out k=%0d got %b exp %b", k, aSerOut, eSer);
            end
            checkCount++;
            if (aDone !== expDone(k, 44)) begin
                errorCount++;
                $display("[TB] FAIL midrst 81 done k=%0d got %b exp %b", k, aDone, expDone(k, 44));
            end
        end
    endtask

    // BAUD_DIV=1, no parity: 10-cycle frame for 0x01, done in cycle 11.
    task automatic test_alt_instance();
        logic eSer;
        @(posedge clk);
        #1;
        bTxData  = 8'h01;
        bTxValid = 1'b1;
        @(posedge clk);
        #1 bTxValid = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            eSer = expBit(8'h01, k, 1, 0, 1'b0);
            checkCount++;
            if (bSerOut !== eSer) begin
                errorCount++;
                $display("[TB] FAIL alt ser_out k=%0d got %b exp %b", k, bSerOut, eSer);
            end
            checkCount++;
            if (bBusy !== expBusy(k, 10) || bDone !== expDone(k, 10)) begin
                errorCount++;
                $display("[TB] FAIL alt busy/done k=%0d got %b%b exp %b%b", k, bBusy, bDone, expBusy(k, 10), expDone(k, 10));
            end
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #100000;
        errorCount++;
        $display("[TB] FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Scenario sequence.
    initial begin
        checkCount = 0;
        errorCount = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_alt_instance();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out on a single line, framed as: start bit (0), data LSB-first, optional parity bit, stop bit (1).
- Each bit is held for BAUD_DIV clock cycles.
- Forms the transmit end of the team's serial link; the matching deserializer samples ser_out.

Parameters:
- DATA_W, 8: payload width in bits; must be >= 2.
- BAUD_DIV, 4: clock cycles per serial bit; must be >= 1.
- PAR_EN, 1: 1 inserts a parity bit after the data; 0 omits it.
- PAR_ODD, 0: 0 selects even parity (parity bit = XOR of the data bits); 1 selects odd parity (the inverse).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_data  input  DATA_W  word to send; sampled only on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress (START..STOP).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (async assert, sync deassert use):
  - ser_out=1, tx_ready=1, busy=0, done=0.
  - state=IDLE; baud counter, bit counter and shift register cleared.
- State machine: IDLE -> START -> DATA -> (PARITY if PAR_EN) -> STOP -> IDLE.
- Handshake:
  - A word is accepted at the rising edge where tx_valid && tx_ready.
  - tx_ready=1 only in IDLE.
  - tx_data is latched into the shift register, and parity is computed from the latched word at accept time.
  - tx_valid may drop without acceptance; there is no penalty.
- Latency: ser_out is registered. The start bit appears in the cycle immediately after the accept edge.
- Bit timing:
  - The baud counter counts 0..BAUD_DIV-1.
  - A bit advances when the counter reaches BAUD_DIV-1; the counter then wraps to 0.
  - Every bit, including start and stop, lasts exactly BAUD_DIV cycles.
- DATA state:
  - ser_out = shift_reg[0]; the register shifts right on each bit advance.
  - The bit counter counts 0..DATA_W-1 and leaves DATA after bit DATA_W-1.
- Frame length: (2 + DATA_W + PAR_EN) * BAUD_DIV cycles of busy=1.
- End of frame:
  - The STOP bit ends, then state returns to IDLE.
  - In that first IDLE cycle: done=1, tx_ready=1, ser_out=1.
  - If tx_valid is high in that cycle, the next start bit begins the following cycle.
  - The minimum inter-frame gap is therefore 1 idle cycle.
- Inputs while busy: tx_valid and tx_data are ignored. Changing tx_data mid-frame must not affect ser_out.
- BAUD_DIV=1: the counter is degenerate (width forced to 1, always wraps); each bit lasts 1 cycle.
- Reset mid-frame:
  - ser_out goes to 1 immediately (asynchronously) and state goes to IDLE.
  - The partial frame is discarded and no done pulse is generated.
  - The next frame after release is fully correct.
- Widths:
  - Bit counter is $clog2(DATA_W) bits.
  - Baud counter is max(1, $clog2(BAUD_DIV)) bits.
  - No counter may wrap outside its defined range.

Decomposition:
- Package serial_link_pkg holds:
  - the state typedef (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
- The deserializer shares the same package.
- One sub-module is natural: baud_tick_gen (param BAUD_DIV; inputs clk, rst_n, en; output tick on the final cycle of each bit; counter clears when en=0).

Test Plan (DATA_W=8, BAUD_DIV=4, PAR_EN=1, PAR_ODD=0 unless stated):
- Reset: hold rst_n=0 for 3 cycles -> ser_out=1, tx_ready=1, busy=0, done=0 throughout.
- Single frame, tx_data=0xA5 -> ser_out sequence is start 0; data 1,0,1,0,0,1,0,1; parity 0; stop 1.
  - Each level lasts 4 cycles; busy=1 for 44 cycles.
  - done is pulsed exactly in cycle 45 after the accept edge.
- Back-to-back, tx_valid held high with 0x00 then 0xFF:
  - Second start bit begins exactly 45 cycles after the first start bit.
  - Both parity bits are 0.
  - Exactly one idle-high cycle separates the frames.
- Busy ignore: during a 0x5A frame, drive tx_valid=1 with tx_data=0x3C, then 0xC3 -> tx_ready stays 0, ser_out carries 0x5A unchanged, and 0x3C is not sent afterward once tx_valid is dropped.
- Mid-frame reset: assert rst_n=0 during the 3rd data bit of 0xFF -> ser_out=1 within the same cycle and no done.
  - After release, a frame of 0x81 gives data 1,0,0,0,0,0,0,1 and parity 0.
- Alternate instance (PAR_EN=0, BAUD_DIV=1, PAR_ODD ignored), tx_data=0x01 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1; done in cycle 11.
